// File: rtl/puf_soc_cnt_ctrl_if.sv
// Handshake and data bundle between the PUF count controller, its ring counter and the
// result consumer.
interface puf_soc_cnt_ctrl_if #(
  parameter int unsigned CNT_BIT_SIZE = 5
);

  logic                    i_start;
  logic                    o_busy;
  logic                    o_cnt_en;
  logic                    i_cnt_valid;
  logic [CNT_BIT_SIZE-1:0] i_cnt;
  logic                    i_cnt_full;
  logic                    o_res_valid;
  logic                    i_res_ready;
  logic [CNT_BIT_SIZE-1:0] o_res_cnt;
  logic                    o_res_timeout;

  // Controller side.
  modport slave (
    input  i_start,
    input  i_cnt_valid,
    input  i_cnt,
    input  i_cnt_full,
    input  i_res_ready,
    output o_busy,
    output o_cnt_en,
    output o_res_valid,
    output o_res_cnt,
    output o_res_timeout
  );

  // Requester / counter / consumer side.
  modport master (
    output i_start,
    output i_cnt_valid,
    output i_cnt,
    output i_cnt_full,
    output i_res_ready,
    input  o_busy,
    input  o_cnt_en,
    input  o_res_valid,
    input  o_res_cnt,
    input  o_res_timeout
  );

endinterface

// File: rtl/puf_soc_cnt_ctrl.sv
// PUF counter measurement controller: runs the counter until full or timeout, holds the
// result under valid/ready, then waits a short re-arm gap before accepting the next start.
module puf_soc_cnt_ctrl #(
  parameter int unsigned CNT_BIT_SIZE = 5,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input logic               clk,
  input logic               rst,
  puf_soc_cnt_ctrl_if.slave bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StGap
  } state_e;

  state_e                  state_q, state_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic [CNT_BIT_SIZE-1:0] last_cnt_q, last_cnt_d;
  logic [CNT_BIT_SIZE-1:0] res_cnt_q, res_cnt_d;
  logic                    res_tmo_q, res_tmo_d;
  logic                    gap_q, gap_d;

  logic full_hit;
  logic tmo_hit;

  assign full_hit = bus.i_cnt_valid & bus.i_cnt_full;
  assign tmo_hit  = (tmo_q == TmoLast);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    last_cnt_d = last_cnt_q;
    res_cnt_d  = res_cnt_q;
    res_tmo_d  = res_tmo_q;
    gap_d      = gap_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d = StRun;
          tmo_d   = '0;
        end
      end
      StRun: begin
        tmo_d      = tmo_q + TmoW'(1);
        last_cnt_d = bus.i_cnt;
        // Full beats timeout when both land on the same cycle.
        if (full_hit) begin
          state_d   = StDone;
          res_cnt_d = bus.i_cnt;
          res_tmo_d = 1'b0;
        end else if (tmo_hit) begin
          state_d   = StDone;
          res_cnt_d = last_cnt_q;
          res_tmo_d = 1'b1;
        end
      end
      StDone: begin
        if (bus.i_res_ready) begin
          state_d = StGap;
          gap_d   = 1'b0;
        end
      end
      StGap: begin
        gap_d = 1'b1;
        if (gap_q) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      last_cnt_q <= '0;
      res_cnt_q  <= '0;
      res_tmo_q  <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      last_cnt_q <= last_cnt_d;
      res_cnt_q  <= res_cnt_d;
      res_tmo_q  <= res_tmo_d;
      gap_q      <= gap_d;
    end
  end

  assign bus.o_busy        = (state_q != StIdle);
  assign bus.o_cnt_en      = (state_q == StRun);
  assign bus.o_res_valid   = (state_q == StDone);
  assign bus.o_res_cnt     = res_cnt_q;
  assign bus.o_res_timeout = res_tmo_q;

endmodule

// File: tb/tb_puf_soc_cnt_ctrl.sv
// Directed bench for puf_soc_cnt_ctrl: full completion, timeout, backpressure, full/timeout
// collision, ignored starts and reset in RUN and DONE.
module tb_puf_soc_cnt_ctrl;

  localparam int unsigned CntW = 5;

  logic clk = 1'b0;
  logic rst;

  int n_asserts = 0;
  int n_fail    = 0;

  puf_soc_cnt_ctrl_if #(.CNT_BIT_SIZE(CntW)) bus ();

  puf_soc_cnt_ctrl #(
    .CNT_BIT_SIZE(CntW),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus.i_start     = 1'b1;
    bus.i_cnt_valid = 1'b0;
    bus.i_cnt_full  = 1'b0;
    bus.i_cnt       = '0;
    bus.i_res_ready = 1'b0;

    // Reset for 5 cycles with start held high: reset must win.
    repeat (5) tick();
    check("rst_busy", bus.o_busy, 0);
    check("rst_cnt_en", bus.o_cnt_en, 0);
    check("rst_res_valid", bus.o_res_valid, 0);
    check("rst_res_cnt", bus.o_res_cnt, 0);
    check("rst_res_timeout", bus.o_res_timeout, 0);

    // Normal completion; start accepted on first cycle after reset release.
    rst         = 1'b0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("run1_busy", bus.o_busy, 1);
    check("run1_cnt_en", bus.o_cnt_en, 1);
    for (int k = 1; k <= 31; k++) begin
      bus.i_cnt   = CntW'(k);
      bus.i_start = (k == 5);
      tick();
    end
    bus.i_start = 1'b0;
    check("run32_cnt_en", bus.o_cnt_en, 1);
    bus.i_cnt       = 5'd31;
    bus.i_cnt_valid = 1'b1;
    bus.i_cnt_full  = 1'b1;
    bus.i_res_ready = 1'b1;
    tick();
    bus.i_cnt_valid = 1'b0;
    bus.i_cnt_full  = 1'b0;
    check("full_res_valid", bus.o_res_valid, 1);
    check("full_res_cnt", bus.o_res_cnt, 31);
    check("full_res_timeout", bus.o_res_timeout, 0);
    check("done_cnt_en", bus.o_cnt_en, 0);
    check("done_busy", bus.o_busy, 1);
    tick();
    check("gap1_res_valid", bus.o_res_valid, 0);
    check("gap1_busy", bus.o_busy, 1);
    check("gap1_cnt_en", bus.o_cnt_en, 0);
    check("gap1_res_cnt_kept", bus.o_res_cnt, 31);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("gap2_busy", bus.o_busy, 1);
    check("gap2_cnt_en", bus.o_cnt_en, 0);
    tick();
    check("idle_after_gap", bus.o_busy, 0);
    tick();
    check("gap_start_dropped", bus.o_busy, 0);

    // Timeout with backpressure.
    bus.i_res_ready = 1'b0;
    bus.i_cnt       = 5'd17;
    bus.i_start     = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (63) tick();
    check("tmo_run64_cnt_en", bus.o_cnt_en, 1);
    check("tmo_run64_res_valid", bus.o_res_valid, 0);
    tick();
    bus.i_cnt = 5'd3;
    for (int i = 0; i < 10; i++) begin
      check("bp_res_valid", bus.o_res_valid, 1);
      check("bp_res_cnt", bus.o_res_cnt, 17);
      check("bp_res_timeout", bus.o_res_timeout, 1);
      tick();
    end
    check("bp_hold_end", bus.o_res_valid, 1);
    bus.i_res_ready = 1'b1;
    tick();
    bus.i_res_ready = 1'b0;
    check("bp_drop_valid", bus.o_res_valid, 0);
    check("bp_keep_cnt", bus.o_res_cnt, 17);
    check("bp_keep_timeout", bus.o_res_timeout, 1);
    tick();
    check("bp_gap2_valid", bus.o_res_valid, 0);
    tick();
    check("bp_idle_busy", bus.o_busy, 0);
    check("bp_idle_valid", bus.o_res_valid, 0);

    // Valid without full keeps running; full and timeout together report full.
    bus.i_cnt   = '0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (9) tick();
    bus.i_cnt_valid = 1'b1;
    tick();
    bus.i_cnt_valid = 1'b0;
    check("valid_no_full", bus.o_cnt_en, 1);
    repeat (53) tick();
    check("coll_run64_cnt_en", bus.o_cnt_en, 1);
    bus.i_cnt       = 5'd9;
    bus.i_cnt_valid = 1'b1;
    bus.i_cnt_full  = 1'b1;
    bus.i_res_ready = 1'b1;
    tick();
    bus.i_cnt_valid = 1'b0;
    bus.i_cnt_full  = 1'b0;
    check("coll_res_valid", bus.o_res_valid, 1);
    check("coll_res_cnt", bus.o_res_cnt, 9);
    check("coll_res_timeout", bus.o_res_timeout, 0);
    repeat (3) tick();
    check("coll_idle", bus.o_busy, 0);

    // Reset during RUN.
    bus.i_res_ready = 1'b0;
    bus.i_cnt       = 5'd4;
    bus.i_start     = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check("rst_run_cnt_en", bus.o_cnt_en, 0);
    check("rst_run_busy", bus.o_busy, 0);
    check("rst_run_res_cnt", bus.o_res_cnt, 0);
    rst         = 1'b0;
    bus.i_cnt   = 5'd5;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (63) tick();
    check("clean1_run64", bus.o_cnt_en, 1);
    tick();
    check("clean1_res_valid", bus.o_res_valid, 1);
    check("clean1_res_cnt", bus.o_res_cnt, 5);
    check("clean1_res_timeout", bus.o_res_timeout, 1);

    // Reset during DONE discards the pending result.
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rst_done_valid", bus.o_res_valid, 0);
    check("rst_done_busy", bus.o_busy, 0);
    check("rst_done_res_cnt", bus.o_res_cnt, 0);
    check("rst_done_timeout", bus.o_res_timeout, 0);
    rst         = 1'b0;
    bus.i_cnt   = 5'd6;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (63) tick();
    check("clean2_run64", bus.o_cnt_en, 1);
    tick();
    check("clean2_res_valid", bus.o_res_valid, 1);
    check("clean2_res_cnt", bus.o_res_cnt, 6);
    check("clean2_res_timeout", bus.o_res_timeout, 1);
    bus.i_res_ready = 1'b1;
    tick();
    bus.i_res_ready = 1'b0;
    check("clean2_gap_valid", bus.o_res_valid, 0);
    repeat (2) tick();
    check("clean2_idle", bus.o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
